dual_beam_trig_scaler: RTL
==========================

# dual_beam_trig_scaler

Downstream stage of the dual-beam DSP threshold pair. It takes the two level-type per-beam trigger bits and turns each rising edge into a single-cycle qualified trigger pulse, applying a programmable per-beam holdoff. It also counts the qualified triggers per beam over a programmable gate period and presents the counts to the register/readout side through a valid/ack handshake. It is instantiated once per dual-beam DSP pair, in the same clock domain.

## Interface
Parameters:
- `SCAL_W`, 16: per-beam scaler width; counts saturate.
- `PERIOD_W`, 24: gate period counter width.
- `HOLDOFF_W`, 8: holdoff counter width.

Ports:
- `clk_i`  in  1  beam clock, same clock as the DSP pair.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `trig_i`  in  2  level trigger from the DSP pair; bit 0 = beam A, bit 1 = beam B.
- `holdoff_i`  in  HOLDOFF_W  holdoff in cycles after an accepted trigger; shared by both beams; quasi-static.
- `period_i`  in  PERIOD_W  gate length minus 1 in cycles; quasi-static.
- `trig_o`  out  2  qualified trigger pulses, one cycle wide per accepted edge.
- `scal_o`  out  2*SCAL_W  latched counts, {B, A}.
- `scal_valid_o`  out  1  `scal_o` holds an unacknowledged gate result.
- `scal_ack_i`  in  1  consumer acknowledge; only meaningful while valid.
- `scal_ovr_o`  out  1  sticky flag: a gate result overwrote an unacknowledged one.

## Operation
- Per beam:
  - `trig_q` is `trig_i` delayed one cycle.
  - Edge = `trig_i & ~trig_q`.
  - Accept = edge & (`hold_cnt` == 0).
  - On accept, `hold_cnt` loads `holdoff_i`. While nonzero, `hold_cnt` decrements by 1 per cycle.
  - Edges arriving while `hold_cnt` != 0 are dropped and are not counted.
  - A level held high produces exactly one accept.
- Per-beam accumulator:
  - Increments on accept.
  - Saturates at 2^SCAL_W−1 and never wraps.
- Gate counter:
  - Counts up from 0.
  - Gate end is the cycle where count == `period_i`; the counter returns to 0 on the next edge.
  - Gate length is `period_i`+1 cycles. `period_i`=0 gives a 1-cycle gate.
- At gate end:
  - `scal_o` ← accumulator values, including any accept in that same cycle.
  - Accumulators clear to 0.
- Handshake FSM, states EMPTY and FULL:
  - EMPTY → FULL on gate end.
  - FULL with `scal_ack_i`=1 and no gate end → EMPTY.
  - FULL with gate end and `scal_ack_i`=1 → FULL. New data is latched and `scal_ovr_o` is not set.
  - FULL with gate end and `scal_ack_i`=0 → FULL. New data overwrites the old and `scal_ovr_o` is set.
  - `scal_ack_i` in EMPTY is ignored.
  - `scal_ovr_o` clears on the cycle after any ack taken in FULL, unless an overwrite happens in that same cycle.
  - `scal_valid_o` is asserted exactly when the FSM is in FULL.
- Reset:
  - Every register clears to 0: `trig_q`, `hold_cnt`, accumulators, gate counter, `scal_o`, FSM (EMPTY), `scal_ovr_o`.
  - Outputs are therefore all 0 during and after reset.
  - Reset mid-gate discards the partial counts. The first post-reset gate is a full `period_i`+1 cycles.
  - `trig_q` resets to 0, so a `trig_i` already high when reset releases counts as an edge on the first clock.

## Timing
- Accept sampled at edge k → `trig_o` is high for the cycle after edge k only. Latency is 1 clock from `trig_i` to `trig_o`.
- Minimum spacing between accepts is `holdoff_i`+1 cycles, because `hold_cnt` loads on the accept edge. Back-to-back edges also need `trig_i` low for ≥1 cycle.
- Gate end sampled at edge k → `scal_o` and `scal_valid_o` update after edge k. The 1-cycle latency includes the same-cycle accept.
- Ack sampled at edge k → `scal_valid_o` is low after edge k, unless a gate end occurs at edge k.
- Changing `holdoff_i` or `period_i` affects only the next load or compare. No glitch handling is required.

## Structure
- Package `beam_trig_pkg`:
  - `typedef enum logic {EMPTY, FULL} scal_state_t`.
  - Beam index localparams `BEAM_A`=0 and `BEAM_B`=1.
- Sub-module `beam_trig_qual`, instantiated twice: edge detect, holdoff counter, saturating accumulator with clear. Its inputs are `gate_end`, `holdoff_i` and `trig_i` bit; its outputs are accept pulse and count.
- The top level holds the gate counter, output register, handshake FSM and overrun flag.

## Test plan
- Reset: assert `rst_ni`=0 asynchronously mid-gate with `trig_i`=2'b11 → all outputs 0 immediately. After release with `period_i`=99, the first `scal_valid_o` appears 100 cycles after the first active edge.
- Holdoff 0, `trig_i[0]` high for 5 cycles → exactly one `trig_o[0]` pulse, 1 cycle after the rising edge. Beam A count is 1.
- Holdoff: `holdoff_i`=10, beam A single-cycle pulses at cycles 0, 4, 8, 12, 16 → `trig_o[0]` at 1 and 13 only. The scaler counts 2.
- Gate: `period_i`=99, 7 accepts on A and 3 on B inside one gate, one on A in the gate-end cycle → `scal_o` = {3, 8}. `scal_valid_o` rises once. Ack → valid drops the next cycle.
- Saturation: `SCAL_W`=4 and 20 accepts in one gate → count 15, with no wrap.
- Overrun: two gates with no ack → `scal_ovr_o`=1 and `scal_o` holds the second gate. Ack asserted in the same cycle as a gate end → valid stays 1, `scal_ovr_o` is cleared, and the new counts are visible.

Source files
------------

// File: rtl/beam_trig_pkg.sv
// Shared types and constants for the dual-beam trigger qualifier/scaler.
package beam_trig_pkg;

    // Readout handshake state: EMPTY = no pending result, FULL = result awaiting ack.
    typedef enum logic {EMPTY, FULL} scal_state_t;

    // Bit position of each beam in trig_i / trig_o and counter slot in scal_o.
    localparam int unsigned BEAM_A = 0;
    localparam int unsigned BEAM_B = 1;

endpackage

// File: rtl/beam_trig_qual.sv
// Per-beam trigger qualifier: rising-edge detect, holdoff, saturating gate accumulator.
module beam_trig_qual
    import beam_trig_pkg::*;
#(
    parameter int unsigned SCAL_W    = 16,
    parameter int unsigned HOLDOFF_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trig_i,
    input  logic                 gate_end_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic                 accept_o,
    output logic [SCAL_W-1:0]    count_o
);

    logic                 trigQ;
    logic                 acceptQ;
    logic                 edgeDet;
    logic                 accept;
    logic [HOLDOFF_W-1:0] holdCntQ, holdCntD;
    logic [SCAL_W-1:0]    accQ, accD, accInc;

    // Edge qualification, holdoff countdown and saturating accumulate/clear.
    always_comb begin
        edgeDet  = trig_i & ~trigQ;
        accept   = edgeDet && (holdCntQ == '0);

        holdCntD = holdCntQ;
        if (accept) begin
            holdCntD = holdoff_i;
        end else if (holdCntQ != '0) begin
            holdCntD = holdCntQ - HOLDOFF_W'(1);
        end

        // accInc includes this cycle's accept so a gate-end capture sees it.
        accInc = accQ;
        if (accept && (accQ != '1)) begin
            accInc = accQ + SCAL_W'(1);
        end
        accD = gate_end_i ? '0 : accInc;
    end

    // State registers; the accept pulse is registered to give a clean 1-cycle trig_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trigQ    <= 1'b0;
            acceptQ  <= 1'b0;
            holdCntQ <= '0;
            accQ     <= '0;
        end else begin
            trigQ    <= trig_i;
            acceptQ  <= accept;
            holdCntQ <= holdCntD;
            accQ     <= accD;
        end
    end

    assign accept_o = acceptQ;
    assign count_o  = accInc;

endmodule

// File: rtl/dual_beam_trig_scaler.sv
// Dual-beam trigger qualifier with gated per-beam scalers and valid/ack readout.
module dual_beam_trig_scaler
    import beam_trig_pkg::*;
#(
    parameter int unsigned SCAL_W    = 16,
    parameter int unsigned PERIOD_W  = 24,
    parameter int unsigned HOLDOFF_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            trig_i,
    input  logic [HOLDOFF_W-1:0]  holdoff_i,
    input  logic [PERIOD_W-1:0]   period_i,
    output logic [1:0]            trig_o,
    output logic [2*SCAL_W-1:0]   scal_o,
    output logic                  scal_valid_o,
    input  logic                  scal_ack_i,
    output logic                  scal_ovr_o
);

    logic [PERIOD_W-1:0] gateCntQ, gateCntD;
    logic                gateEnd;
    logic [SCAL_W-1:0]   countA, countB;
    logic [2*SCAL_W-1:0] scalQ, scalD;
    scal_state_t         stateQ, stateD;
    logic                ovrQ, ovrD;

    beam_trig_qual #(
        .SCAL_W    (SCAL_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_qual_a (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .trig_i     (trig_i[BEAM_A]),
        .gate_end_i (gateEnd),
        .holdoff_i  (holdoff_i),
        .accept_o   (trig_o[BEAM_A]),
        .count_o    (countA)
    );

    beam_trig_qual #(
        .SCAL_W    (SCAL_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_qual_b (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .trig_i     (trig_i[BEAM_B]),
        .gate_end_i (gateEnd),
        .holdoff_i  (holdoff_i),
        .accept_o   (trig_o[BEAM_B]),
        .count_o    (countB)
    );

    // Gate counter: runs 0..period_i, gate end on the terminal count.
    always_comb begin
        gateEnd  = (gateCntQ == period_i);
        gateCntD = gateEnd ? '0 : gateCntQ + PERIOD_W'(1);
    end

    // Handshake next state, result capture and overrun flag.
    always_comb begin
        stateD = stateQ;
        ovrD   = ovrQ;
        scalD  = scalQ;
        if (gateEnd) begin
            scalD = {countB, countA};
        end
        unique case (stateQ)
            EMPTY: begin
                if (gateEnd) begin
                    stateD = FULL;
                end
            end
            FULL: begin
                if (gateEnd) begin
                    // An ack in the same cycle consumes the old result, so no overwrite.
                    ovrD = ~scal_ack_i;
                end else if (scal_ack_i) begin
                    stateD = EMPTY;
                    ovrD   = 1'b0;
                end
            end
        endcase
    end

    // Top-level state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gateCntQ <= '0;
            scalQ    <= '0;
            stateQ   <= EMPTY;
            ovrQ     <= 1'b0;
        end else begin
            gateCntQ <= gateCntD;
            scalQ    <= scalD;
            stateQ   <= stateD;
            ovrQ     <= ovrD;
        end
    end

    assign scal_o       = scalQ;
    assign scal_valid_o = (stateQ == FULL);
    assign scal_ovr_o   = ovrQ;

endmodule
